sr_cmd_gen: RTL and testbench
=============================

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive synchronized cycles an input must differ from its filtered level before the level changes; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, debounce counter width; SHALL satisfy 2^CNT_W > DB_CYCLES.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 set_raw  input  1  asynchronous, bouncy set request (e.g. pushbutton).
REQ-006 clr_raw  input  1  asynchronous, bouncy clear request.
REQ-007 s  output  1  registered one-cycle set pulse, drives downstream SR flip-flop s.
REQ-008 r  output  1  registered one-cycle clear pulse, drives downstream SR flip-flop r.
REQ-009 set_level  output  1  registered debounced level of set_raw.
REQ-010 clr_level  output  1  registered debounced level of clr_raw.
REQ-011 conflict  output  1  registered one-cycle flag: both filtered levels rose on the same edge.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer; only the second-stage output (sync) feeds downstream logic.
REQ-013 Per channel: sync == level -> counter cleared to 0, level held.
REQ-014 Per channel: sync != level and counter < DB_CYCLES-1 -> counter incremented, level held.
REQ-015 Per channel: sync != level and counter == DB_CYCLES-1 -> level toggles, counter cleared to 0.
REQ-016 Any cycle with sync == level during a count SHALL restart the count (no accumulation across glitches).
REQ-017 A rising edge of set_level alone SHALL produce s=1 for exactly one cycle on the following edge; same for clr_level -> r.
REQ-018 Falling edges of set_level/clr_level SHALL produce no pulse.
REQ-019 Both levels rising on the same edge -> s=0, r=0, conflict=1 for one cycle (never s=r=1).
REQ-020 s and r SHALL never be high in the same cycle; each pulse SHALL be exactly one cycle wide.
REQ-021 Latency: raw input first sampled stable at edge k -> level changes at edge k+1+DB_CYCLES -> pulse high after edge k+2+DB_CYCLES, low after edge k+3+DB_CYCLES.
REQ-022 Holding an input high indefinitely SHALL produce a single pulse; a new pulse requires level to return to 0 and rise again.
REQ-023 Counters SHALL never exceed DB_CYCLES-1 and SHALL not wrap.
REQ-024 DB_CYCLES=1: level follows sync with one edge delay, pulse one edge later.
REQ-025 Channels SHALL be fully independent except for the conflict rule in REQ-019.

Reset
REQ-026 reset=1 at an edge SHALL clear synchronizer flops, counters, set_level, clr_level, s, r, conflict to 0, overriding all other behaviour.
REQ-027 Pulse in flight at reset SHALL be dropped; reset mid-count SHALL discard the count.
REQ-028 Input held high across reset deassertion SHALL be treated as a fresh rising input: pulse per REQ-021 counted from first post-reset sampling edge.

Verification
REQ-029 DB_CYCLES=4: set_raw 0->1 sampled at edge 10, held -> set_level=1 after edge 15, s=1 after edge 16 only, r=0, conflict=0 throughout.
REQ-030 DB_CYCLES=4: set_raw high 3 cycles then low, repeated 5 times -> set_level stays 0, no s pulse.
REQ-031 set_raw and clr_raw rise together (same sampling edge) -> conflict=1 one cycle, s=0, r=0; set_raw then dropped, clr_raw held -> no further pulses.
REQ-032 clr_raw pulse train of bounces (1,0,1,1,0 cycles) ending in stable 1 -> exactly one r pulse, timed from start of final stable run.
REQ-033 reset asserted for 1 cycle during a count (counter=2) and while s high -> all outputs 0 next cycle; set_raw still high -> s pulse DB_CYCLES+2 edges after reset release.
REQ-034 Drive downstream SR flip-flop from s/r: set then clear sequence -> q goes 1 then 0, q never sees s=r=1.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// ----------------------------------------------------------------------------
// sr_cmd_gen
// Turns two asynchronous, bouncy request inputs (set / clear) into clean
// one-cycle command pulses for a downstream SR flip-flop.
//
// Each channel passes through a 2-flop synchronizer and a debounce filter.
// The filtered level changes only after the synchronized input has differed
// from it for DB_CYCLES consecutive edges. A rising edge of a filtered level
// produces a single registered pulse. If both levels rise on the same edge,
// neither pulse is issued and a one-cycle conflict flag is raised instead, so
// s and r are never high together.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous reset, active-high
//   set_raw    in   asynchronous bouncy set request
//   clr_raw    in   asynchronous bouncy clear request
//   s          out  one-cycle set pulse
//   r          out  one-cycle clear pulse
//   set_level  out  debounced level of set_raw
//   clr_level  out  debounced level of clr_raw
//   conflict   out  one-cycle flag, both levels rose together
// ----------------------------------------------------------------------------
module sr_cmd_gen #(
   parameter int DB_CYCLES = 4,   // 1..255
   parameter int CNT_W     = 8    // 2**CNT_W > DB_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic set_raw,
   input  logic clr_raw,
   output logic s,
   output logic r,
   output logic set_level,
   output logic clr_level,
   output logic conflict
);

   // Terminal count: the level flips on the edge where the counter sits here
   // and the synchronized input still disagrees with the level.
   localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DB_CYCLES - 1);

   // Channel index 0 = set, 1 = clear.
   logic [1:0]       w_raw;
   logic [1:0]       w_rise;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_level;
   logic [1:0]       r_level_d;
   logic [CNT_W-1:0] r_cnt [2];
   logic             r_s;
   logic             r_r;
   logic             r_conflict;

   assign w_raw  = {clr_raw, set_raw};
   assign w_rise = r_level & ~r_level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_level    <= '0;
         r_level_d  <= '0;
         r_cnt[0]   <= '0;
         r_cnt[1]   <= '0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;

         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_level[i]) begin
               // Agreement at any point restarts the count, so glitches
               // never accumulate toward a level change.
               r_cnt[i] <= '0;
            end else if (r_cnt[i] >= DB_TC) begin
               r_level[i] <= ~r_level[i];
               r_cnt[i]   <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end

         r_level_d  <= r_level;
         r_s        <= w_rise[0] & ~w_rise[1];
         r_r        <= w_rise[1] & ~w_rise[0];
         r_conflict <= w_rise[0] &  w_rise[1];
      end
   end

   assign s         = r_s;
   assign r         = r_r;
   assign set_level = r_level[0];
   assign clr_level = r_level[1];
   assign conflict  = r_conflict;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// ----------------------------------------------------------------------------
// tb_sr_cmd_gen
// Directed bench for sr_cmd_gen (DB_CYCLES=4 main instance, DB_CYCLES=1
// secondary instance sharing the inputs). A behavioural SR flip-flop driven by
// the main instance's s/r models the downstream consumer.
// Inputs change 1 time unit after a rising edge, so the next rising edge is
// the sampling edge k. Outputs are observed 1 time unit after each edge.
// ----------------------------------------------------------------------------
module tb_sr_cmd_gen;

   logic clk = 1'b0;
   logic reset;
   logic set_raw;
   logic clr_raw;
   logic s, r, set_level, clr_level, conflict;
   logic s1, r1, set_level1, clr_level1, conflict1;
   logic q;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sr_cmd_gen #(.DB_CYCLES(4), .CNT_W(8)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .set_raw   (set_raw),
      .clr_raw   (clr_raw),
      .s         (s),
      .r         (r),
      .set_level (set_level),
      .clr_level (clr_level),
      .conflict  (conflict)
   );

   sr_cmd_gen #(.DB_CYCLES(1), .CNT_W(2)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .set_raw   (set_raw),
      .clr_raw   (clr_raw),
      .s         (s1),
      .r         (r1),
      .set_level (set_level1),
      .clr_level (clr_level1),
      .conflict  (conflict1)
   );

   // Downstream SR flip-flop fed by the main instance.
   always_ff @(posedge clk) begin
      if (reset)  q <= 1'b0;
      else if (s) q <= 1'b1;
      else if (r) q <= 1'b0;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one edge; s and r must never be high together on any cycle.
   task automatic step();
      @(posedge clk);
      #1;
      check_val("s_r_exclusive", {31'd0, s & r}, 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_s"},         {31'd0, s},         0);
      check_val({tag, "_r"},         {31'd0, r},         0);
      check_val({tag, "_set_level"}, {31'd0, set_level}, 0);
      check_val({tag, "_clr_level"}, {31'd0, clr_level}, 0);
      check_val({tag, "_conflict"},  {31'd0, conflict},  0);
   endtask

   initial begin
      reset   = 1'b1;
      set_raw = 1'b0;
      clr_raw = 1'b0;
      steps(2);
      check_all_zero("reset");
      reset = 1'b0;
      steps(6);

      // Single set request held: level after k+5, s only after k+6.
      // DB_CYCLES=1 instance: level after k+2, s1 only after k+3.
      set_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         check_val("t1_set_level", {31'd0, set_level}, (e >= 5) ? 1 : 0);
         check_val("t1_s",         {31'd0, s},         (e == 6) ? 1 : 0);
         check_val("t1_r",         {31'd0, r},         0);
         check_val("t1_conflict",  {31'd0, conflict},  0);
         check_val("t1_db1_level", {31'd0, set_level1}, (e >= 2) ? 1 : 0);
         check_val("t1_db1_s",     {31'd0, s1},         (e == 3) ? 1 : 0);
      end
      check_val("t1_q", {31'd0, q}, 1);

      // Release: falling level, no pulse.
      set_raw = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step();
         check_val("t1f_s", {31'd0, s}, 0);
      end
      check_val("t1f_set_level", {31'd0, set_level}, 0);

      // Short 3-cycle bursts never reach the terminal count.
      for (int rep = 0; rep < 5; rep++) begin
         set_raw = 1'b1;
         for (int e = 0; e < 3; e++) begin
            step();
            check_val("t2_set_level", {31'd0, set_level}, 0);
            check_val("t2_s",         {31'd0, s},         0);
         end
         set_raw = 1'b0;
         for (int e = 0; e < 3; e++) begin
            step();
            check_val("t2_set_level", {31'd0, set_level}, 0);
            check_val("t2_s",         {31'd0, s},         0);
         end
      end
      steps(4);

      // Both rise on the same sampling edge: conflict only.
      set_raw = 1'b1;
      clr_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         check_val("t3_conflict",  {31'd0, conflict},  (e == 6) ? 1 : 0);
         check_val("t3_s",         {31'd0, s},         0);
         check_val("t3_r",         {31'd0, r},         0);
         check_val("t3_clr_level", {31'd0, clr_level}, (e >= 5) ? 1 : 0);
      end
      set_raw = 1'b0;
      for (int e = 0; e < 12; e++) begin
         step();
         check_val("t3b_s",        {31'd0, s},        0);
         check_val("t3b_r",        {31'd0, r},        0);
         check_val("t3b_conflict", {31'd0, conflict}, 0);
      end
      check_val("t3b_set_level", {31'd0, set_level}, 0);
      check_val("t3b_clr_level", {31'd0, clr_level}, 1);
      clr_raw = 1'b0;
      steps(10);
      check_val("t3c_clr_level", {31'd0, clr_level}, 0);

      // Clear bounces 1,0,1,1,0 then stable 1: one r pulse from final run.
      clr_raw = 1'b1; step();
      clr_raw = 1'b0; step();
      clr_raw = 1'b1; steps(2);
      clr_raw = 1'b0; step();
      clr_raw = 1'b1;
      for (int e = 0; e < 12; e++) begin
         step();
         check_val("t4_r",         {31'd0, r},         (e == 6) ? 1 : 0);
         check_val("t4_clr_level", {31'd0, clr_level}, (e >= 5) ? 1 : 0);
         check_val("t4_s",         {31'd0, s},         0);
      end
      clr_raw = 1'b0;
      steps(10);

      // Reset mid-count (counter = 2 after edge k+3), set_raw kept high.
      set_raw = 1'b1;
      steps(4);
      reset = 1'b1;
      step();
      check_all_zero("t5a_rst");
      reset = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step();
         check_val("t5a_s",         {31'd0, s},         (e == 6) ? 1 : 0);
         check_val("t5a_set_level", {31'd0, set_level}, (e >= 5) ? 1 : 0);
      end

      // Reset while s is high: pulse dropped, then a fresh pulse.
      set_raw = 1'b0;
      steps(10);
      set_raw = 1'b1;
      steps(7);
      check_val("t5b_s_before", {31'd0, s}, 1);
      reset = 1'b1;
      step();
      check_all_zero("t5b_rst");
      reset = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step();
         check_val("t5b_s", {31'd0, s}, (e == 6) ? 1 : 0);
      end
      check_val("t6_q_set", {31'd0, q}, 1);

      // Clear the downstream flop: q falls the edge after r.
      set_raw = 1'b0;
      clr_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         check_val("t6_r", {31'd0, r}, (e == 6) ? 1 : 0);
         check_val("t6_q", {31'd0, q}, (e < 7) ? 1 : 0);
      end
      clr_raw = 1'b0;
      steps(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
